// File: rtl/lane_reorder_pkg.sv
// Shared sizing defaults and the identity lane map for the lane reorder block.
// Selector field k sits at the MS end for k = 0, matching the data bus lane order.
package lane_reorder_pkg;

    localparam int N_LANES_DEF = 20;
    localparam int NB_DATA_DEF = 66;
    localparam int NB_ID_DEF   = $clog2(N_LANES_DEF);
    localparam int SEL_MAX_W   = 1024;

    // Field k = k, field 0 ending up in the MSBs of the low n_lanes*nb_id bits.
    function automatic logic [SEL_MAX_W-1:0] identity_sel(input int n_lanes, input int nb_id);
        logic [SEL_MAX_W-1:0] r;
        r = '0;
        for (int k = 0; k < n_lanes; k++) begin
            r = (r << nb_id) | SEL_MAX_W'(k);
        end
        return r;
    endfunction

    localparam logic [N_LANES_DEF*NB_ID_DEF-1:0] SEL_IDENTITY =
        (N_LANES_DEF*NB_ID_DEF)'(identity_sel(N_LANES_DEF, NB_ID_DEF));

endpackage

// File: rtl/lane_sel_check.sv
// Purpose: flags whether a lane selector bus is a true permutation of 0..N_LANES-1.
// Latency: combinational.
// Backpressure: none.
module lane_sel_check
    import lane_reorder_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int NB_ID   = $clog2(N_LANES)
) (
    input  logic [N_LANES*NB_ID-1:0] sel,
    output logic                     ok
);

    logic [N_LANES-1:0] seen;
    logic [NB_ID-1:0]   field;

    // N in-range fields with no repeats cover every lane exactly once.
    always_comb begin
        seen  = '0;
        field = '0;
        ok    = 1'b1;
        for (int k = 0; k < N_LANES; k++) begin
            field = sel[(N_LANES-1-k)*NB_ID +: NB_ID];
            if (32'(field) >= N_LANES) begin
                ok = 1'b0;
            end else if (seen[field]) begin
                ok = 1'b0;
            end else begin
                seen[field] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_reorder_mux.sv
// Purpose: reorders physical PCS lane blocks into logical order via a checked selector.
// Latency: 2 enabled edges i_valid -> o_valid, one block set per enabled cycle.
// Backpressure: none; i_enable low freezes every register.
module lane_reorder_mux
    import lane_reorder_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ID   = $clog2(N_LANES)
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic [N_LANES*NB_DATA-1:0] i_data,
    input  logic [N_LANES*NB_ID-1:0]   i_reorder_mux_selector,
    input  logic                       i_update_selectors,
    input  logic                       i_clear_error,
    output logic [N_LANES*NB_DATA-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_sel_error,
    output logic [7:0]                 o_update_count
);

    localparam int DATA_W = N_LANES*NB_DATA;
    localparam int SEL_W  = N_LANES*NB_ID;
    localparam logic [SEL_W-1:0] SEL_RESET = SEL_W'(identity_sel(N_LANES, NB_ID));

    logic [SEL_W-1:0]   sel_q;
    logic [DATA_W-1:0]  s1_data;
    logic               s1_valid;
    logic               sel_ok;
    logic               upd_accept;
    logic               upd_reject;
    logic [DATA_W-1:0]  mux_data;
    logic [NB_DATA-1:0] s1_lane [N_LANES];

    lane_sel_check #(
        .N_LANES (N_LANES),
        .NB_ID   (NB_ID)
    ) u_sel_check (
        .sel (i_reorder_mux_selector),
        .ok  (sel_ok)
    );

    assign upd_accept = i_update_selectors &  sel_ok;
    assign upd_reject = i_update_selectors & ~sel_ok;

    // A rejected update in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sel_q          <= SEL_RESET;
            o_sel_error    <= 1'b0;
            o_update_count <= '0;
        end else if (i_enable) begin
            if (upd_accept) begin
                sel_q <= i_reorder_mux_selector;
                if (o_update_count != 8'hFF) begin
                    o_update_count <= o_update_count + 8'd1;
                end
            end
            if (upd_reject) begin
                o_sel_error <= 1'b1;
            end else if (i_clear_error) begin
                o_sel_error <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (i_enable) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_data <= i_data;
            end
        end
    end

    for (genvar j = 0; j < N_LANES; j++) begin : g_s1_lane
        assign s1_lane[j] = s1_data[(N_LANES-1-j)*NB_DATA +: NB_DATA];
    end

    // sel_q only ever holds a checked permutation, so every index is in range.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N_LANES; k++) begin
            mux_data[(N_LANES-1-k)*NB_DATA +: NB_DATA] = s1_lane[sel_q[(N_LANES-1-k)*NB_ID +: NB_ID]];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_enable) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data <= mux_data;
            end
        end
    end

endmodule

// File: tb/tb_lane_reorder_mux.sv
// Randomised bench for lane_reorder_mux: a block-level scoreboard predicts every output
// from the offered blocks and the accepted selector history; directed steps pin literals.
module tb_lane_reorder_mux;

    localparam int N   = 20;
    localparam int NBD = 66;
    localparam int NBI = 5;
    localparam int DW  = N*NBD;
    localparam int SW  = N*NBI;

    typedef logic [DW-1:0] data_t;
    typedef logic [SW-1:0] sel_t;

    logic  clk;
    logic  rst_n;
    logic  en;
    logic  vld;
    logic  upd;
    logic  clr;
    data_t din;
    sel_t  sel;
    data_t dout;
    logic  ovld;
    logic  oerr;
    logic [7:0] ocnt;

    int checks   = 0;
    int failures = 0;

    lane_reorder_mux #(
        .N_LANES (N),
        .NB_DATA (NBD),
        .NB_ID   (NBI)
    ) dut (
        .i_clock                (clk),
        .i_reset_n              (rst_n),
        .i_enable               (en),
        .i_valid                (vld),
        .i_data                 (din),
        .i_reorder_mux_selector (sel),
        .i_update_selectors     (upd),
        .i_clear_error          (clr),
        .o_data                 (dout),
        .o_valid                (ovld),
        .o_sel_error            (oerr),
        .o_update_count         (ocnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sel_field(input sel_t s, input int k);
        return int'(s[(N-1-k)*NBI +: NBI]);
    endfunction

    function automatic sel_t pack_sel(input int f[N]);
        sel_t s = '0;
        for (int k = 0; k < N; k++) s[(N-1-k)*NBI +: NBI] = NBI'(f[k]);
        return s;
    endfunction

    function automatic logic [NBD-1:0] lane(input data_t d, input int k);
        return d[(N-1-k)*NBD +: NBD];
    endfunction

    function automatic data_t permute(input data_t d, input sel_t s);
        data_t r = '0;
        for (int k = 0; k < N; k++) r[(N-1-k)*NBD +: NBD] = lane(d, sel_field(s, k));
        return r;
    endfunction

    function automatic bit is_perm(input sel_t s);
        int hits[N];
        foreach (hits[i]) hits[i] = 0;
        for (int k = 0; k < N; k++) begin
            int v = sel_field(s, k);
            if (v >= N) return 1'b0;
            hits[v]++;
        end
        foreach (hits[i]) if (hits[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic sel_t map_sel(input bit rev);
        int f[N];
        for (int k = 0; k < N; k++) f[k] = rev ? (N-1-k) : k;
        return pack_sel(f);
    endfunction

    // Lane j carries j, or N-1-j when rev is set.
    function automatic data_t ramp(input bit rev);
        data_t d = '0;
        for (int j = 0; j < N; j++) d[(N-1-j)*NBD +: NBD] = NBD'(rev ? (N-1-j) : j);
        return d;
    endfunction

    function automatic sel_t rand_perm();
        int f[N];
        for (int k = 0; k < N; k++) f[k] = k;
        for (int k = N-1; k > 0; k--) begin
            int j = int'($urandom_range(k, 0));
            int t = f[k];
            f[k] = f[j];
            f[j] = t;
        end
        return pack_sel(f);
    endfunction

    function automatic data_t rand_data();
        data_t d = '0;
        for (int k = 0; k < N; k++) d[(N-1-k)*NBD +: NBD] = NBD'({$urandom, $urandom, $urandom});
        return d;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input data_t act, input data_t exp);
        checks++;
        if (act !== exp) begin
            int bad = 0;
            failures++;
            for (int k = N-1; k >= 0; k--) if (lane(act, k) !== lane(exp, k)) bad = k;
            $display("FAIL %s lane=%0d actual=%h required=%h", name, bad, lane(act, bad), lane(exp, bad));
        end
    endtask

    // Scoreboard: each block offered at an enabled edge is stored already permuted by the
    // selector in force after that edge, and must surface on the next enabled edge.
    sel_t  m_sel;
    int    m_cnt;
    bit    m_err;
    bit    m_vld_prev;
    bit    m_ovld;
    data_t m_held;
    data_t exp_q[$];
    int    n_in;
    int    n_out;
    bit    edge_en;

    always @(posedge clk) begin
        edge_en = rst_n && en;
        if (!rst_n) begin
            m_sel      = map_sel(1'b0);
            m_cnt      = 0;
            m_err      = 1'b0;
            m_vld_prev = 1'b0;
            m_ovld     = 1'b0;
            m_held     = '0;
            n_in       = 0;
            n_out      = 0;
            exp_q.delete();
        end else if (en) begin
            if (upd && is_perm(sel)) begin
                m_sel = sel;
                if (m_cnt < 255) m_cnt++;
            end
            if (upd && !is_perm(sel)) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            m_ovld = m_vld_prev;
            if (m_vld_prev && exp_q.size() > 0) m_held = exp_q.pop_front();
            if (vld) begin
                exp_q.push_back(permute(din, m_sel));
                n_in++;
            end
            m_vld_prev = vld;
        end
        #1;
        if (edge_en && ovld) n_out++;
        chk("cyc_o_valid", int'(ovld), int'(m_ovld));
        chk_data("cyc_o_data", dout, m_held);
        chk("cyc_o_sel_error", int'(oerr), int'(m_err));
        chk("cyc_o_update_count", int'(ocnt), m_cnt);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int accepted;

    initial begin
        sel_t bad;
        rst_n = 1'b0;
        en    = 1'b0;
        vld   = 1'b0;
        upd   = 1'b0;
        clr   = 1'b0;
        din   = '0;
        sel   = map_sel(1'b0);
        tick();
        tick();
        chk("reset_o_valid", int'(ovld), 0);
        chk_data("reset_o_data", dout, '0);
        chk("reset_o_sel_error", int'(oerr), 0);
        chk("reset_o_update_count", int'(ocnt), 0);

        // Identity mapping straight out of reset.
        rst_n = 1'b1;
        en    = 1'b1;
        vld   = 1'b1;
        din   = ramp(1'b0);
        tick();
        chk("boot_first_edge_o_valid", int'(ovld), 0);
        tick();
        chk("boot_o_valid", int'(ovld), 1);
        chk_data("boot_identity", dout, ramp(1'b0));
        chk("boot_count", int'(ocnt), 0);

        // Reversed map: the update edge itself still uses the old map.
        sel = map_sel(1'b1);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        chk_data("rev_update_edge_old_map", dout, ramp(1'b0));
        tick();
        chk_data("rev_applied", dout, ramp(1'b1));
        chk("rev_count", int'(ocnt), 1);

        // Duplicate entry: rejected, map and count untouched, clear works.
        bad = map_sel(1'b1);
        bad[(N-1-3)*NBI +: NBI] = NBI'(7);
        bad[(N-1-5)*NBI +: NBI] = NBI'(7);
        sel = bad;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        chk("dup_sel_error", int'(oerr), 1);
        chk("dup_count", int'(ocnt), 1);
        tick();
        chk_data("dup_map_kept", dout, ramp(1'b1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("dup_cleared", int'(oerr), 0);

        // Out-of-range entry together with a clear: rejection wins.
        bad = map_sel(1'b1);
        bad[(N-1)*NBI +: NBI] = NBI'(25);
        sel = bad;
        upd = 1'b1;
        clr = 1'b1;
        tick();
        upd = 1'b0;
        clr = 1'b0;
        chk("range_err_beats_clear", int'(oerr), 1);
        chk("range_count", int'(ocnt), 1);

        // Random stream, enable low every third cycle, until 300 updates accepted.
        accepted = 0;
        for (int c = 0; c < 6000 && accepted < 300; c++) begin
            en  = (c % 3) != 2;
            vld = $urandom_range(9, 0) != 0;
            din = rand_data();
            clr = $urandom_range(7, 0) == 0;
            upd = $urandom_range(1, 0) == 1;
            sel = rand_perm();
            if ($urandom_range(6, 0) == 0) begin
                int a = int'($urandom_range(N-1, 0));
                int b = (a + 1 + int'($urandom_range(N-2, 0))) % N;
                if ($urandom_range(1, 0) == 1) sel[(N-1-a)*NBI +: NBI] = sel[(N-1-b)*NBI +: NBI];
                else sel[(N-1-a)*NBI +: NBI] = NBI'($urandom_range(31, N));
            end
            if (en && upd && is_perm(sel)) accepted++;
            tick();
        end
        chk("stream_accepted_reached", accepted, 300);
        en  = 1'b1;
        vld = 1'b0;
        upd = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        tick();
        chk("stream_drained_o_valid", int'(ovld), 0);
        chk("stream_no_lost_or_dup", n_out, n_in);
        chk("stream_count_saturated", int'(ocnt), 255);

        // Reset with two blocks in flight under a reversed map.
        sel = map_sel(1'b1);
        upd = 1'b1;
        vld = 1'b1;
        din = ramp(1'b0);
        tick();
        upd = 1'b0;
        tick();
        tick();
        chk("inflight_o_valid", int'(ovld), 1);
        chk_data("inflight_rev", dout, ramp(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_o_valid", int'(ovld), 0);
        chk_data("async_reset_o_data", dout, '0);
        chk("async_reset_count", int'(ocnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_first_edge", int'(ovld), 0);
        tick();
        chk("post_reset_o_valid", int'(ovld), 1);
        chk_data("post_reset_identity", dout, ramp(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
